// File: rtl/minisrc_control_unit.sv
// Hardwired control sequencer for the Mini SRC datapath.
// Optional build macro: MINISRC_STEP_EN (single-step via Step input).
//
// Ports:
//   Clock, Clear (async active-low)     clocking and reset
//   IR[31:0], BranchOut, Stop           instruction, CON result, halt request
//   Step (MINISRC_STEP_EN only)         single-step advance from HALT
//   Run, DP_Clear                       sequencer status, datapath clear
//   *out / *in / Gr* / ALU ops          bus-drive, load, select, ALU strobes
//   Read, Write                         memory strobes
//
// Strobes are decoded only from flops: the state register, the wait
// counter, and the IR and CON registers that live in the datapath. IR is
// reloaded at the end of T2 and its new value is needed during T3, so the
// decode cannot be pre-registered one cycle early; decoding straight from
// registers still gives strobes that are stable across the whole cycle.
module minisrc_control_unit #(
    parameter int MEM_WAIT = 0
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        BranchOut,
    input  logic        Stop,
`ifdef MINISRC_STEP_EN
    input  logic        Step,
`endif
    output logic        Run,
    output logic        DP_Clear,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        Rin,
    output logic        CONin,
    output logic        OutPortIn,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        Read,
    output logic        Write
);

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T1W,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T6W,
        S_T7,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20;
    localparam logic [4:0] OP_JR   = 5'd21;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [1:0] WAIT_N = MEM_WAIT[1:0];

    state_t     state;
    logic [1:0] cnt;
    logic       hard_halt;
    logic [4:0] opcode;
    logic [2:0] last;
    logic       is_reg;
    logic       is_imm;
    logic       is_md;
    logic       is_nn;
    logic       op_en;
    logic       step_rise;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    assign is_reg = (opcode >= OP_ADD) && (opcode <= OP_SHL);
    assign is_imm = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
    assign is_md  = (opcode == OP_DIV) || (opcode == OP_MUL);
    assign is_nn  = (opcode == OP_NEG) || (opcode == OP_NOT);

`ifdef MINISRC_STEP_EN
    logic step_q;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            step_q <= 1'b0;
        end else begin
            step_q <= Step;
        end
    end

    assign step_rise = Step & ~step_q;
    localparam state_t DONE_NEXT = S_HALT;
`else
    assign step_rise = 1'b0;
    localparam state_t DONE_NEXT = S_T0;
`endif

    // Final execution step of each opcode (T3..T7)
    always_comb begin
        last = 3'd3;
        unique case (1'b1)
            is_reg, is_imm:     last = 3'd5;
            is_md:              last = 3'd6;
            is_nn:              last = 3'd4;
            opcode == OP_LD:    last = 3'd7;
            opcode == OP_LDI:   last = 3'd5;
            opcode == OP_ST:    last = 3'd6;
            opcode == OP_BR:    last = 3'd6;
            opcode == OP_JAL:   last = 3'd4;
            default:            last = 3'd3;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state     <= S_RESET;
            cnt       <= 2'd0;
            hard_halt <= 1'b0;
        end else begin
            unique case (state)
                S_RESET: state <= S_T0;
                S_T0: state <= Stop ? S_HALT : S_T1;
                S_T1: begin
                    if (WAIT_N == 2'd0) begin
                        state <= S_T2;
                    end else begin
                        state <= S_T1W;
                        cnt   <= 2'd1;
                    end
                end
                S_T1W: begin
                    if (cnt == WAIT_N) begin
                        state <= S_T2;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_T2: state <= S_T3;
                S_T3: begin
                    if (opcode == OP_HALT) begin
                        state     <= S_HALT;
                        hard_halt <= 1'b1;
                    end else if (last == 3'd3) begin
                        state <= DONE_NEXT;
                    end else begin
                        state <= S_T4;
                    end
                end
                S_T4: state <= (last == 3'd4) ? DONE_NEXT : S_T5;
                S_T5: state <= (last == 3'd5) ? DONE_NEXT : S_T6;
                S_T6: begin
                    if (opcode != OP_LD) begin
                        state <= DONE_NEXT;
                    end else if (WAIT_N == 2'd0) begin
                        state <= S_T7;
                    end else begin
                        state <= S_T6W;
                        cnt   <= 2'd1;
                    end
                end
                S_T6W: begin
                    if (cnt == WAIT_N) begin
                        state <= S_T7;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_T7: state <= DONE_NEXT;
                S_HALT: begin
                    if (step_rise && !hard_halt) begin
                        state <= S_T0;
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout,
         Cout, BAout, Rout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin,
         OutPortIn} = '0;
        {Gra, Grb, Grc} = '0;
        {IncPC, ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL,
         NEG, NOT} = '0;
        {Read, Write} = '0;
        op_en    = 1'b0;
        Run      = (state != S_RESET) && (state != S_HALT);
        DP_Clear = (state == S_RESET);

        unique case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = (WAIT_N == 2'd0);
            end
            S_T1W, S_T6W: begin
                Read  = 1'b1;
                MDRin = (cnt == WAIT_N);
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                unique case (1'b1)
                    is_reg, is_imm: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    is_md: begin
                        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    is_nn: begin
                        Grb = 1'b1; Rout = 1'b1;
                        op_en = 1'b1; Zin = 1'b1;
                    end
                    opcode <= OP_ST: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                    opcode == OP_BR: begin
                        Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                    end
                    opcode == OP_JR: begin
                        Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                    end
                    opcode == OP_JAL: begin
                        PCout = 1'b1; Grb = 1'b1; Rin = 1'b1;
                    end
                    opcode == OP_IN: begin
                        InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    opcode == OP_OUT: begin
                        Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1;
                    end
                    opcode == OP_MFHI: begin
                        HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    opcode == OP_MFLO: begin
                        LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                unique case (1'b1)
                    is_reg: begin
                        Grc = 1'b1; Rout = 1'b1;
                        op_en = 1'b1; Zin = 1'b1;
                    end
                    is_imm: begin
                        Cout = 1'b1; op_en = 1'b1; Zin = 1'b1;
                    end
                    is_md: begin
                        Grb = 1'b1; Rout = 1'b1;
                        op_en = 1'b1; Zin = 1'b1;
                    end
                    is_nn: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    opcode <= OP_ST: begin
                        Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
                    end
                    opcode == OP_BR: begin
                        PCout = 1'b1; Yin = 1'b1;
                    end
                    opcode == OP_JAL: begin
                        Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                unique case (1'b1)
                    is_reg, is_imm, opcode == OP_LDI: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    is_md: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                    end
                    opcode == OP_LD, opcode == OP_ST: begin
                        Zlowout = 1'b1; MARin = 1'b1;
                    end
                    opcode == OP_BR: begin
                        Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                unique case (1'b1)
                    is_md: begin
                        Zhighout = 1'b1; HIin = 1'b1;
                    end
                    opcode == OP_LD: begin
                        Read  = 1'b1;
                        MDRin = (WAIT_N == 2'd0);
                    end
                    opcode == OP_ST: begin
                        Gra = 1'b1; Rout = 1'b1; Write = 1'b1;
                    end
                    opcode == OP_BR: begin
                        Zlowout = BranchOut;
                        PCin    = BranchOut;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            default: ;
        endcase

        // One ALU op per cycle, chosen by the opcode
        if (op_en) begin
            unique case (opcode)
                OP_ADD, OP_ADDI: ADD  = 1'b1;
                OP_SUB:          SUB  = 1'b1;
                OP_AND, OP_ANDI: AND  = 1'b1;
                OP_OR, OP_ORI:   OR   = 1'b1;
                OP_ROR:          ROR  = 1'b1;
                OP_ROL:          ROL  = 1'b1;
                OP_SHR:          SHR  = 1'b1;
                OP_SHRA:         SHRA = 1'b1;
                OP_SHL:          SHL  = 1'b1;
                OP_DIV:          DIV  = 1'b1;
                OP_MUL:          MUL  = 1'b1;
                OP_NEG:          NEG  = 1'b1;
                OP_NOT:          NOT  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minisrc_control_unit.sv
// Randomised bench for minisrc_control_unit: two instances (MEM_WAIT 0
// and 2) run the same programs against a per-cycle expected strobe stream.
module tb_minisrc_control_unit;

    typedef struct packed {
        logic Run, DP_Clear;
        logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
        logic InPortout, Cout, BAout, Rout;
        logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
        logic Rin, CONin, OutPortIn;
        logic Gra, Grb, Grc;
        logic IncPC, ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL;
        logic ROR, ROL, NEG, NOT;
        logic Read, Write;
    } strobes_t;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] ir_v [2];
    logic        br_v [2];
    logic        stop_v [2];
    wire strobes_t so [2];

    int          idx [2];
    logic [31:0] prog_ir [$];
    bit          prog_br [$];
    strobes_t    exp0 [$];
    strobes_t    exp1 [$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        minisrc_control_unit #(.MEM_WAIT(2 * g)) dut (
            .Clock(clk), .Clear(clear), .IR(ir_v[g]),
            .BranchOut(br_v[g]), .Stop(stop_v[g]),
            .Run(so[g].Run), .DP_Clear(so[g].DP_Clear),
            .PCout(so[g].PCout), .Zlowout(so[g].Zlowout),
            .Zhighout(so[g].Zhighout), .MDRout(so[g].MDRout),
            .HIout(so[g].HIout), .LOout(so[g].LOout),
            .InPortout(so[g].InPortout), .Cout(so[g].Cout),
            .BAout(so[g].BAout), .Rout(so[g].Rout),
            .PCin(so[g].PCin), .IRin(so[g].IRin),
            .MARin(so[g].MARin), .MDRin(so[g].MDRin),
            .Yin(so[g].Yin), .Zin(so[g].Zin),
            .HIin(so[g].HIin), .LOin(so[g].LOin),
            .Rin(so[g].Rin), .CONin(so[g].CONin),
            .OutPortIn(so[g].OutPortIn),
            .Gra(so[g].Gra), .Grb(so[g].Grb), .Grc(so[g].Grc),
            .IncPC(so[g].IncPC), .ADD(so[g].ADD),
            .SUB(so[g].SUB), .MUL(so[g].MUL), .DIV(so[g].DIV),
            .AND(so[g].AND), .OR(so[g].OR), .SHR(so[g].SHR),
            .SHRA(so[g].SHRA), .SHL(so[g].SHL),
            .ROR(so[g].ROR), .ROL(so[g].ROL),
            .NEG(so[g].NEG), .NOT(so[g].NOT),
            .Read(so[g].Read), .Write(so[g].Write)
        );
    end

    // Datapath stand-in: IR/CON take the next program word when IRin fires
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (so[g].IRin && idx[g] < prog_ir.size()) begin
                ir_v[g] = prog_ir[idx[g]];
                br_v[g] = prog_br[idx[g]];
                idx[g]  = idx[g] + 1;
            end
            stop_v[g] = (idx[g] >= prog_ir.size());
        end
    end

    task automatic check(input string tag, input strobes_t got,
                         input strobes_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic strobes_t busy();
        strobes_t s = '0;
        s.Run = 1'b1;
        return s;
    endfunction

    function automatic strobes_t reset_mask();
        strobes_t s = '0;
        s.DP_Clear = 1'b1;
        return s;
    endfunction

    function automatic strobes_t with_alu(input strobes_t s0,
                                          input int op);
        strobes_t s = s0;
        case (op)
            3, 12:  s.ADD = 1'b1;
            4:      s.SUB = 1'b1;
            5, 13:  s.AND = 1'b1;
            6, 14:  s.OR = 1'b1;
            7:      s.ROR = 1'b1;
            8:      s.ROL = 1'b1;
            9:      s.SHR = 1'b1;
            10:     s.SHRA = 1'b1;
            11:     s.SHL = 1'b1;
            15:     s.DIV = 1'b1;
            16:     s.MUL = 1'b1;
            17:     s.NEG = 1'b1;
            18:     s.NOT = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    task automatic push(input int g, input strobes_t s);
        if (g == 0) exp0.push_back(s);
        else exp1.push_back(s);
    endtask

    // A memory read lasts mw+1 cycles; MDRin only in the final one
    task automatic push_read(input int g, input int mw, input bit fetch);
        strobes_t s;
        for (int i = 0; i <= mw; i++) begin
            s = busy();
            s.Read = 1'b1;
            if (fetch && i == 0) begin
                s.Zlowout = 1'b1;
                s.PCin = 1'b1;
            end
            if (i == mw) s.MDRin = 1'b1;
            push(g, s);
        end
    endtask

    function automatic strobes_t t0_mask();
        strobes_t s = busy();
        s.PCout = 1'b1; s.MARin = 1'b1; s.IncPC = 1'b1; s.Zin = 1'b1;
        return s;
    endfunction

    task automatic model_instr(input int g, input logic [31:0] ir,
                               input bit br, output bit halted);
        strobes_t s;
        int op = int'(ir[31:27]);
        int mw = 2 * g;
        halted = 1'b0;
        push(g, t0_mask());
        push_read(g, mw, 1'b1);
        s = busy(); s.MDRout = 1; s.IRin = 1; push(g, s);
        if (op >= 3 && op <= 14) begin
            s = busy(); s.Grb = 1; s.Rout = 1; s.Yin = 1; push(g, s);
            s = busy(); s.Zin = 1;
            if (op >= 12) s.Cout = 1;
            else begin s.Grc = 1; s.Rout = 1; end
            push(g, with_alu(s, op));
            s = busy(); s.Zlowout = 1; s.Gra = 1; s.Rin = 1; push(g, s);
        end else if (op == 15 || op == 16) begin
            s = busy(); s.Gra = 1; s.Rout = 1; s.Yin = 1; push(g, s);
            s = busy(); s.Grb = 1; s.Rout = 1; s.Zin = 1;
            push(g, with_alu(s, op));
            s = busy(); s.Zlowout = 1; s.LOin = 1; push(g, s);
            s = busy(); s.Zhighout = 1; s.HIin = 1; push(g, s);
        end else if (op == 17 || op == 18) begin
            s = busy(); s.Grb = 1; s.Rout = 1; s.Zin = 1;
            push(g, with_alu(s, op));
            s = busy(); s.Zlowout = 1; s.Gra = 1; s.Rin = 1; push(g, s);
        end else if (op <= 2) begin
            s = busy(); s.Grb = 1; s.BAout = 1; s.Yin = 1; push(g, s);
            s = busy(); s.Cout = 1; s.ADD = 1; s.Zin = 1; push(g, s);
            s = busy(); s.Zlowout = 1;
            if (op == 1) begin s.Gra = 1; s.Rin = 1; end
            else s.MARin = 1;
            push(g, s);
            if (op == 0) begin
                push_read(g, mw, 1'b0);
                s = busy(); s.MDRout = 1; s.Gra = 1; s.Rin = 1;
                push(g, s);
            end else if (op == 2) begin
                s = busy(); s.Gra = 1; s.Rout = 1; s.Write = 1;
                push(g, s);
            end
        end else if (op == 19) begin
            s = busy(); s.Gra = 1; s.Rout = 1; s.CONin = 1; push(g, s);
            s = busy(); s.PCout = 1; s.Yin = 1; push(g, s);
            s = busy(); s.Cout = 1; s.ADD = 1; s.Zin = 1; push(g, s);
            s = busy(); s.Zlowout = br; s.PCin = br; push(g, s);
        end else if (op == 20) begin
            s = busy(); s.PCout = 1; s.Grb = 1; s.Rin = 1; push(g, s);
            s = busy(); s.Gra = 1; s.Rout = 1; s.PCin = 1; push(g, s);
        end else begin
            s = busy();
            case (op)
                21: begin s.Gra = 1; s.Rout = 1; s.PCin = 1; end
                22: begin s.InPortout = 1; s.Gra = 1; s.Rin = 1; end
                23: begin s.Gra = 1; s.Rout = 1; s.OutPortIn = 1; end
                24: begin s.HIout = 1; s.Gra = 1; s.Rin = 1; end
                25: begin s.LOout = 1; s.Gra = 1; s.Rin = 1; end
                default: ;
            endcase
            push(g, s);
            halted = (op == 27);
        end
    endtask

    // Expected stream from the cycle after Clear rises; HALT (all 0) after
    task automatic build();
        bit h;
        exp0.delete();
        exp1.delete();
        for (int g = 0; g < 2; g++) begin
            push(g, reset_mask());
            h = 1'b0;
            for (int i = 0; i < prog_ir.size() && !h; i++)
                model_instr(g, prog_ir[i], prog_br[i], h);
            if (!h) push(g, t0_mask());
        end
    endtask

    function automatic strobes_t exp_at(input int g, input int k);
        if (g == 0) return (k < exp0.size()) ? exp0[k] : '0;
        return (k < exp1.size()) ? exp1[k] : '0;
    endfunction

    task automatic do_reset();
        clear = 1'b0;
        for (int g = 0; g < 2; g++) begin
            idx[g] = 0;
            stop_v[g] = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++)
                check($sformatf("reset mw%0d", 2 * g), so[g], reset_mask());
        end
        @(posedge clk);
        #1 clear = 1'b1;
    endtask

    task automatic run_cmp(input int from, input int to, input string nm);
        for (int k = from; k < to; k++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++)
                check($sformatf("%s mw%0d cyc%0d", nm, 2 * g, k),
                      so[g], exp_at(g, k));
        end
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] op;
        do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
        return {op, 27'($urandom)};
    endfunction

    task automatic add_prog(input logic [31:0] ir, input bit br);
        prog_ir.push_back(ir);
        prog_br.push_back(br);
    endtask

    initial begin
        int n;
        for (int g = 0; g < 2; g++) begin
            ir_v[g] = '0; br_v[g] = 1'b0; stop_v[g] = 1'b0; idx[g] = 0;
        end

        // Directed opcodes, random mix, then halt opcode
        add_prog(32'h18918000, 1'b0);
        add_prog(32'h00800010, 1'b0);
        add_prog(32'h9A000005, 1'b1);
        add_prog(32'h9A000005, 1'b0);
        add_prog(32'h80918000, 1'b0);
        for (int i = 0; i < 30; i++) add_prog(rand_ir(), 1'($urandom));
        add_prog(32'hD8000000, 1'b0);
        do_reset();
        build();
        n = (exp0.size() > exp1.size()) ? exp0.size() : exp1.size();
        run_cmp(0, n + 20, "prog1");

        // Random program ended by Stop at T0
        prog_ir.delete();
        prog_br.delete();
        for (int i = 0; i < 25; i++) add_prog(rand_ir(), 1'($urandom));
        do_reset();
        build();
        n = (exp0.size() > exp1.size()) ? exp0.size() : exp1.size();
        run_cmp(0, n + 10, "prog2");

        // st aborted by Clear during T4 (MEM_WAIT=0 instance)
        prog_ir.delete();
        prog_br.delete();
        add_prog(32'h10800010, 1'b0);
        do_reset();
        build();
        run_cmp(0, 6, "st_pre");
        #1 clear = 1'b0;
        #1;
        for (int g = 0; g < 2; g++)
            check($sformatf("async_clr mw%0d", 2 * g), so[g], reset_mask());
        do_reset();
        build();
        n = (exp0.size() > exp1.size()) ? exp0.size() : exp1.size();
        run_cmp(0, n + 5, "st_restart");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
